// File: rtl/dda_ctrl_seq_pkg.sv
// Shared types and defaults for the DDA sequencing controller.
// Command packing is {sel_a, sel_b, op}, MSB first.
package dda_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ALU_IN,
    EXEC,
    WB,
    ERR
  } state_t;

  localparam int DEF_SEL_W     = 2;
  localparam int DEF_CMD_OP_W  = 3;
  localparam int DEF_OP_W      = 5;
  localparam int DEF_MC_LAT    = 3;
  localparam int DEF_ERR_CNT_W = 8;

  function automatic int op_lsb();
    return 0;
  endfunction

  function automatic int selb_lsb(input int op_w);
    return op_w;
  endfunction

  function automatic int sela_lsb(input int sel_w,
                                  input int op_w);
    return op_w + sel_w;
  endfunction

endpackage

// File: rtl/dda_ctrl_seq_if.sv
// Command valid/ready channel into the controller.
// The master modport is the command source.
interface dda_ctrl_seq_if #(
  parameter int CMD_W = 7
);
  logic [CMD_W-1:0] cmd_in;
  logic             cmd_valid;
  logic             cmd_ready;

  modport master (
    output cmd_in,
    output cmd_valid,
    input  cmd_ready
  );

  modport slave (
    input  cmd_in,
    input  cmd_valid,
    output cmd_ready
  );
endinterface

// File: rtl/dda_ctrl_seq_sat_counter.sv
// Saturating up-counter with synchronous clear.
// Holds at all-ones once reached.
module dda_sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);
  logic [W-1:0] cnt_q;

  // count up on enable, stick at the top value
  always_ff @(posedge clk) begin
    if (clr_i) begin
      cnt_q <= '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_q <= cnt_q + W'(1);
    end
  end

  assign cnt_o = cnt_q;
endmodule

// File: rtl/dda_ctrl_seq.sv
// Load/execute/write-back sequencer for the DDA datapath.
// Holds mux selects and opcode for the whole operation.
import dda_ctrl_pkg::*;

module dda_ctrl_seq #(
  parameter int SEL_W     = DEF_SEL_W,
  parameter int CMD_OP_W  = DEF_CMD_OP_W,
  parameter int OP_W      = DEF_OP_W,
  parameter int MC_LAT    = DEF_MC_LAT,
  parameter int ERR_CNT_W = DEF_ERR_CNT_W
) (
  input  logic                 clk,
  input  logic                 rst,
  dda_ctrl_seq_if.slave        cmd_if,
  input  logic                 p_error,
  output logic                 datain_reg_en,
  output logic                 aluin_reg_en,
  output logic                 aluout_reg_en,
  output logic                 nvalid_data,
  output logic [SEL_W-1:0]     in_select_a,
  output logic [SEL_W-1:0]     in_select_b,
  output logic [OP_W-1:0]      opcode,
  output logic                 busy,
  output logic [ERR_CNT_W-1:0] err_cnt
);
  localparam int CMD_W = 2 * SEL_W + CMD_OP_W;
  localparam int OPL   = op_lsb();
  localparam int SBL   = selb_lsb(CMD_OP_W);
  localparam int SAL   = sela_lsb(SEL_W, CMD_OP_W);
  localparam int CNT_W = $clog2(MC_LAT + 1);

  state_t           state_q;
  logic [CMD_W-1:0] cmd_q;
  logic [CNT_W-1:0] cnt_q;
  logic             accept;
  logic             is_mc;

  assign cmd_if.cmd_ready =
    ((state_q == IDLE) || (state_q == WB)) && !rst;
  assign accept = cmd_if.cmd_valid && cmd_if.cmd_ready;
  assign is_mc  = cmd_q[OPL + CMD_OP_W - 1];

  // sequencer state, command register and EXEC countdown
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cmd_q   <= '0;
      cnt_q   <= '0;
    end else begin
      if (accept) begin
        cmd_q <= cmd_if.cmd_in;
      end
      unique case (state_q)
        IDLE: begin
          if (accept) state_q <= LOAD;
        end
        LOAD: begin
          state_q <= ALU_IN;
        end
        ALU_IN: begin
          if (p_error) begin
            state_q <= ERR;
          end else begin
            state_q <= EXEC;
            cnt_q   <= is_mc ? CNT_W'(MC_LAT - 1)
                             : '0;
          end
        end
        EXEC: begin
          if (cnt_q == '0) state_q <= WB;
          else cnt_q <= cnt_q - CNT_W'(1);
        end
        WB: begin
          state_q <= accept ? LOAD : IDLE;
        end
        ERR: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign datain_reg_en = (state_q == LOAD);
  assign aluin_reg_en  = (state_q == ALU_IN) && !p_error;
  assign aluout_reg_en = (state_q == WB);
  assign nvalid_data   = (state_q == ERR);
  assign busy          = (state_q != IDLE);

  assign in_select_a = cmd_q[SAL +: SEL_W];
  assign in_select_b = cmd_q[SBL +: SEL_W];
  assign opcode      = OP_W'(cmd_q[OPL +: CMD_OP_W]);

  dda_sat_counter #(
    .W (ERR_CNT_W)
  ) u_err_cnt (
    .clk   (clk),
    .clr_i (rst),
    .inc_i (state_q == ERR),
    .cnt_o (err_cnt)
  );
endmodule
